// File: rtl/tx_pkg.sv
// tx_pkg: constants, read-FSM state type and the Manchester encoder used
// by the TX framer.
//   PREAMBLE_WORD : word repeated at the start of every frame
//   SFD_WORD      : start-of-frame delimiter word after the preamble
//   MAX_LEN       : largest frame (in bytes) the framer accepts
//   tx_state_t    : read-side FSM states
//   manchester()  : byte -> 16-bit word, MSB first, 1 -> 2'b10, 0 -> 2'b01
package tx_pkg;

    localparam logic [15:0] PREAMBLE_WORD = 16'hAAAA;
    localparam logic [15:0] SFD_WORD      = 16'hF0F0;
    localparam int          MAX_LEN       = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_LEN_H,
        ST_LEN_L,
        ST_PAY,
        ST_GAP
    } tx_state_t;

    // Bit i of the byte lands in word bits [2i+1:2i], so the byte MSB
    // ends up in the word MSBs and is serialised first.
    function automatic logic [15:0] manchester(input logic [7:0] b);
        logic [15:0] w;
        for (int i = 0; i < 8; i++) begin
            w[2*i +: 2] = b[i] ? 2'b10 : 2'b01;
        end
        return w;
    endfunction

endpackage

// File: rtl/tx_sync_fifo.sv
// tx_sync_fifo: single-clock FIFO with registered read data and a
// write-pointer bookmark so a partially written frame can be discarded.
//   clk, rst_n          : clock, asynchronous active-low reset
//   wr_en, wr_data      : write one entry
//   mark_en             : remember the position of the entry written now
//   rewind_en           : write pointer returns to the remembered position
//                         (a simultaneous write lands at that position)
//   rd_en, rd_data      : pop one entry; rd_data is valid the next cycle
//   full, empty         : status, from pointers carrying one extra wrap bit
import tx_pkg::*;

module tx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             mark_en,
    input  logic             rewind_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      mark;
    logic [AW:0]      wr_base;

    assign wr_base = rewind_en ? mark : wr_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            mark   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_base + {{AW{1'b0}}, 1'b1};
            end else if (rewind_en) begin
                wr_ptr <= mark;
            end
            if (mark_en) begin
                mark <= wr_base;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_base[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_ptr[AW-1:0]];
            rd_ptr  <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/tx_man_framer.sv
// tx_man_framer: buffers RS-encoded bytes per frame and emits each
// committed frame as 16-bit words: preamble, SFD, Manchester length
// (high, low), Manchester payload, followed by an idle gap.
//   i_vl_tx_clk, i_vl_tx_rst_n       : clock, asynchronous active-low reset
//   i_valid, i_sof, i_eof, i_data    : byte input, no backpressure
//   o_data, o_valid, o_sof, o_eof    : word output, held while i_ready=0
//   i_ready                          : downstream accepts the word
//   o_ovf, i_ovf_clr                 : sticky drop flag and its clear
import tx_pkg::*;

module tx_man_framer #(
    parameter int FIFO_AW   = 10,
    parameter int PRE_WORDS = 4,
    parameter int GAP_CYC   = 8
) (
    input  logic        i_vl_tx_clk,
    input  logic        i_vl_tx_rst_n,
    input  logic        i_valid,
    input  logic        i_sof,
    input  logic        i_eof,
    input  logic [7:0]  i_data,
    output logic [15:0] o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_sof,
    output logic        o_eof,
    output logic        o_ovf,
    input  logic        i_ovf_clr
);

    logic        byte_full, byte_empty, len_full, len_empty;
    logic [7:0]  byte_rd;
    logic [10:0] len_rd;
    logic        byte_pop, len_pop;

    logic        in_frame;
    logic [10:0] byte_cnt;
    logic [10:0] byte_num;
    logic        restart, active, bad, good, rewind_en;

    // Bytes outside an open frame are ignored unless they start one, which
    // also covers the drop mode that follows a discarded frame. A restart
    // rewinds over the open frame's bytes, so byte_full cannot block it.
    assign restart   = i_valid & i_sof & in_frame;
    assign active    = i_valid & (i_sof | in_frame);
    assign byte_num  = i_sof ? 11'd1 : byte_cnt + 11'd1;
    assign bad       = active & ((~restart & byte_full) |
                                 (byte_num > 11'(MAX_LEN)) |
                                 (i_eof & len_full));
    assign good      = active & ~bad;
    assign rewind_en = in_frame & (restart | bad);

    always_ff @(posedge i_vl_tx_clk or negedge i_vl_tx_rst_n) begin
        if (!i_vl_tx_rst_n) begin
            in_frame <= 1'b0;
            byte_cnt <= '0;
        end else if (good) begin
            byte_cnt <= byte_num;
            in_frame <= ~i_eof;
        end else if (bad) begin
            in_frame <= 1'b0;
        end
    end

    always_ff @(posedge i_vl_tx_clk or negedge i_vl_tx_rst_n) begin
        if (!i_vl_tx_rst_n) begin
            o_ovf <= 1'b0;
        end else if (restart | bad) begin
            o_ovf <= 1'b1;
        end else if (i_ovf_clr) begin
            o_ovf <= 1'b0;
        end
    end

    tx_sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_byte_fifo (
        .clk       (i_vl_tx_clk),
        .rst_n     (i_vl_tx_rst_n),
        .wr_en     (good),
        .wr_data   (i_data),
        .mark_en   (good & i_sof),
        .rewind_en (rewind_en),
        .rd_en     (byte_pop),
        .rd_data   (byte_rd),
        .full      (byte_full),
        .empty     (byte_empty)
    );

    tx_sync_fifo #(.WIDTH(11), .AW(3)) u_len_fifo (
        .clk       (i_vl_tx_clk),
        .rst_n     (i_vl_tx_rst_n),
        .wr_en     (good & i_eof),
        .wr_data   (byte_num),
        .mark_en   (1'b0),
        .rewind_en (1'b0),
        .rd_en     (len_pop),
        .rd_data   (len_rd),
        .full      (len_full),
        .empty     (len_empty)
    );

    tx_state_t   state, state_d;
    logic [10:0] cnt, cnt_d;
    logic        load_en, valid_d, sof_d, eof_d;
    logic [15:0] word_d;

    always_ff @(posedge i_vl_tx_clk or negedge i_vl_tx_rst_n) begin
        if (!i_vl_tx_rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_eof   <= 1'b0;
            o_data  <= 16'h0000;
        end else if (load_en) begin
            state   <= state_d;
            cnt     <= cnt_d;
            o_valid <= valid_d;
            o_sof   <= sof_d;
            o_eof   <= eof_d;
            if (valid_d) begin
                o_data <= word_d;
            end
        end
    end

    // The FSM produces the word for the output register, so it only moves
    // when that register is free or being emptied. IDLE also waits for
    // i_ready so frames stay in the length FIFO while the sink is stalled.
    // The IDLE cycle plus the one after it are idle too, so GAP lasts
    // GAP_CYC-1 cycles (GAP_CYC must be at least 2). The first payload byte
    // is fetched during LEN_L because the byte FIFO read is registered.
    always_comb begin
        load_en  = ~o_valid | i_ready;
        state_d  = state;
        cnt_d    = cnt;
        valid_d  = 1'b0;
        sof_d    = 1'b0;
        eof_d    = 1'b0;
        word_d   = 16'h0000;
        len_pop  = 1'b0;
        byte_pop = 1'b0;
        if (load_en) begin
            case (state)
                ST_IDLE: begin
                    if (~len_empty & i_ready) begin
                        len_pop = 1'b1;
                        state_d = ST_PRE;
                        cnt_d   = '0;
                    end
                end
                ST_PRE: begin
                    valid_d = 1'b1;
                    word_d  = PREAMBLE_WORD;
                    sof_d   = (cnt == '0);
                    if (cnt == 11'(PRE_WORDS - 1)) begin
                        state_d = ST_SFD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 11'd1;
                    end
                end
                ST_SFD: begin
                    valid_d = 1'b1;
                    word_d  = SFD_WORD;
                    state_d = ST_LEN_H;
                end
                ST_LEN_H: begin
                    valid_d = 1'b1;
                    word_d  = manchester({5'b0, len_rd[10:8]});
                    state_d = ST_LEN_L;
                end
                ST_LEN_L: begin
                    valid_d  = 1'b1;
                    word_d   = manchester(len_rd[7:0]);
                    byte_pop = ~byte_empty;
                    state_d  = ST_PAY;
                    cnt_d    = '0;
                end
                ST_PAY: begin
                    valid_d = 1'b1;
                    word_d  = manchester(byte_rd);
                    if (cnt == len_rd - 11'd1) begin
                        eof_d   = 1'b1;
                        state_d = ST_GAP;
                        cnt_d   = '0;
                    end else begin
                        byte_pop = ~byte_empty;
                        cnt_d    = cnt + 11'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt == 11'(GAP_CYC - 2)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 11'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_man_framer.sv
// tb_tx_man_framer: directed bench for tx_man_framer. A frame-level model
// turns each frame that must be committed into its expected word list;
// a compare process checks every transferred word, stall stability and
// inter-frame gaps against it.
module tb_tx_man_framer;

    localparam int PRE_WORDS = 4;
    localparam int GAP_CYC   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_sof = 1'b0;
    logic        i_eof = 1'b0;
    logic [7:0]  i_data = 8'h00;
    logic        i_ready = 1'b0;
    logic        i_ovf_clr = 1'b0;
    logic [15:0] o_data;
    logic        o_valid, o_sof, o_eof, o_ovf;

    always #5 clk = ~clk;

    tx_man_framer #(.FIFO_AW(10), .PRE_WORDS(PRE_WORDS), .GAP_CYC(GAP_CYC)) dut (
        .i_vl_tx_clk   (clk),
        .i_vl_tx_rst_n (rst_n),
        .i_valid       (i_valid),
        .i_sof         (i_sof),
        .i_eof         (i_eof),
        .i_data        (i_data),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_sof         (o_sof),
        .o_eof         (o_eof),
        .o_ovf         (o_ovf),
        .i_ovf_clr     (i_ovf_clr)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        sof;
        logic        eof;
    } word_t;

    word_t exp_q[$];
    word_t got_w;
    word_t held;
    int    checks = 0;
    int    failures = 0;
    bit    gap_check_en = 1'b0;
    bit    toggle_en = 1'b0;
    bit    stalled = 1'b0;
    bit    after_eof = 1'b0;
    int    idle_cnt = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Manchester by summing per-bit symbol values: 1 -> 2, 0 -> 1.
    function automatic logic [15:0] manEnc(input logic [7:0] b);
        int acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc += 2 << (2 * i);
            else      acc += 1 << (2 * i);
        end
        return acc[15:0];
    endfunction

    function automatic logic [7:0] payByte(input int base, input int i);
        int v;
        v = (base + i * 37) % 256;
        return v[7:0];
    endfunction

    task automatic pushWord(input logic [15:0] d, input logic s, input logic e);
        word_t w;
        w.data = d;
        w.sof  = s;
        w.eof  = e;
        exp_q.push_back(w);
    endtask

    task automatic modelFrame(input int n, input int base);
        for (int p = 0; p < PRE_WORDS; p++) pushWord(16'hAAAA, p == 0, 1'b0);
        pushWord(16'hF0F0, 1'b0, 1'b0);
        pushWord(manEnc(8'(n / 256)), 1'b0, 1'b0);
        pushWord(manEnc(8'(n % 256)), 1'b0, 1'b0);
        for (int i = 0; i < n; i++) pushWord(manEnc(payByte(base, i)), 1'b0, i == n - 1);
    endtask

    task automatic pushLiteralFrame;
        pushWord(16'hAAAA, 1'b1, 1'b0);
        pushWord(16'hAAAA, 1'b0, 1'b0);
        pushWord(16'hAAAA, 1'b0, 1'b0);
        pushWord(16'hAAAA, 1'b0, 1'b0);
        pushWord(16'hF0F0, 1'b0, 1'b0);
        pushWord(16'h5555, 1'b0, 1'b0);
        pushWord(16'h555A, 1'b0, 1'b0);
        pushWord(16'h9966, 1'b0, 1'b0);
        pushWord(16'h5555, 1'b0, 1'b0);
        pushWord(16'hAAAA, 1'b0, 1'b1);
    endtask

    task automatic syncDrive;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic s, input logic e);
        i_valid = 1'b1;
        i_data  = d;
        i_sof   = s;
        i_eof   = e;
        syncDrive();
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_eof   = 1'b0;
    endtask

    task automatic sendFrame(input int n, input int base);
        for (int i = 0; i < n; i++) applyStimulus(payByte(base, i), i == 0, i == n - 1);
    endtask

    task automatic waitDrain(input string name);
        int c = 0;
        while ((exp_q.size() != 0 || o_valid) && c < 4000) begin
            syncDrive();
            c++;
        end
        checkOutput({name, "_drain_in_time"}, 32'(c < 4000), 32'd1);
        checkOutput({name, "_words_left"}, exp_q.size(), 0);
    endtask

    task automatic clearOvf;
        i_ovf_clr = 1'b1;
        syncDrive();
        i_ovf_clr = 1'b0;
        @(negedge clk);
        checkOutput("ovf_cleared", o_ovf, 1'b0);
        syncDrive();
    endtask

    // Output checker: one word per transfer, stall stability, gap length.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled   = 1'b0;
            after_eof = 1'b0;
            idle_cnt  = 0;
        end else begin
            if (stalled) begin
                checkOutput("hold_valid", o_valid, 1'b1);
                checkOutput("hold_data", o_data, held.data);
                checkOutput("hold_flags", {o_sof, o_eof}, {held.sof, held.eof});
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL extra_word: got 0x%0h expected no word at %0t", o_data, $time);
                end else begin
                    got_w = exp_q.pop_front();
                    checkOutput("word_data", o_data, got_w.data);
                    checkOutput("word_sof", o_sof, got_w.sof);
                    checkOutput("word_eof", o_eof, got_w.eof);
                end
                if (o_sof && after_eof && gap_check_en) checkOutput("gap_cycles", idle_cnt, GAP_CYC);
                if (o_sof) after_eof = 1'b0;
                if (o_eof) begin
                    after_eof = 1'b1;
                    idle_cnt  = 0;
                end
            end else if (!o_valid && after_eof) begin
                idle_cnt++;
            end
            stalled   = o_valid && !i_ready;
            held.data = o_data;
            held.sof  = o_sof;
            held.eof  = o_eof;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) i_ready = ~i_ready;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", o_valid, 1'b0);
        checkOutput("rst_data", o_data, 16'h0000);
        checkOutput("rst_sof", o_sof, 1'b0);
        checkOutput("rst_eof", o_eof, 1'b0);
        checkOutput("rst_ovf", o_ovf, 1'b0);
        syncDrive();
        rst_n   = 1'b1;
        i_ready = 1'b1;
        repeat (2) syncDrive();

        // Single 3-byte frame, sink always ready, with first-word latency
        pushLiteralFrame();
        applyStimulus(8'hA5, 1'b1, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        applyStimulus(8'hFF, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("lat_cycle1", o_valid, 1'b0);
        @(negedge clk);
        checkOutput("lat_cycle2", o_valid, 1'b0);
        @(negedge clk);
        checkOutput("lat_first_word", o_valid, 1'b1);
        checkOutput("lat_first_sof", o_sof, 1'b1);
        syncDrive();
        waitDrain("frame3");
        for (int k = 0; k < GAP_CYC; k++) begin
            @(negedge clk);
            checkOutput("idle_after_frame", o_valid, 1'b0);
        end
        checkOutput("frame3_ovf", o_ovf, 1'b0);
        syncDrive();

        // Same frame with i_ready toggling every cycle
        pushLiteralFrame();
        toggle_en = 1'b1;
        applyStimulus(8'hA5, 1'b1, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        applyStimulus(8'hFF, 1'b0, 1'b1);
        waitDrain("toggle");
        toggle_en = 1'b0;
        syncDrive();
        i_ready = 1'b1;
        repeat (4) syncDrive();

        // Oversized frame is dropped, the following 10-byte frame survives
        sendFrame(1025, 3);
        modelFrame(10, 50);
        sendFrame(10, 50);
        waitDrain("after_oversize");
        checkOutput("oversize_ovf", o_ovf, 1'b1);
        clearOvf();

        // New sof after 5 bytes discards the open frame
        for (int i = 0; i < 5; i++) applyStimulus(payByte(90, i), i == 0, 1'b0);
        modelFrame(4, 120);
        sendFrame(4, 120);
        waitDrain("restart");
        checkOutput("restart_ovf", o_ovf, 1'b1);
        clearOvf();

        // Nine 1-byte frames while stalled: eight fit, the ninth is dropped
        i_ready = 1'b0;
        for (int f = 0; f < 8; f++) modelFrame(1, 200 + f);
        for (int f = 0; f < 9; f++) sendFrame(1, 200 + f);
        repeat (20) syncDrive();
        @(negedge clk);
        checkOutput("lenfull_ovf", o_ovf, 1'b1);
        syncDrive();
        after_eof    = 1'b0;
        gap_check_en = 1'b1;
        i_ready      = 1'b1;
        waitDrain("eight_frames");
        gap_check_en = 1'b0;
        clearOvf();

        // Reset during the payload of a 100-byte frame
        modelFrame(100, 7);
        sendFrame(100, 7);
        repeat (20) syncDrive();
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", o_valid, 1'b0);
        checkOutput("midrst_data", o_data, 16'h0000);
        checkOutput("midrst_sof", o_sof, 1'b0);
        checkOutput("midrst_eof", o_eof, 1'b0);
        checkOutput("midrst_ovf", o_ovf, 1'b0);
        exp_q.delete();
        syncDrive();
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            checkOutput("post_reset_idle", o_valid, 1'b0);
        end
        syncDrive();
        modelFrame(2, 77);
        sendFrame(2, 77);
        waitDrain("post_reset_frame");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_man_framer.md
TX_MAN_FRAMER -- requirements
Module: tx_man_framer

Interface
REQ-001 SHALL have parameter FIFO_AW, default 10, byte-FIFO address width (depth 1024 bytes).
REQ-002 SHALL have parameter PRE_WORDS, default 4, number of 16'hAAAA preamble words.
REQ-003 SHALL have parameter GAP_CYC, default 8, minimum idle cycles (o_valid low) between frames.
REQ-004 SHALL have port i_vl_tx_clk, input, 1, the clock; all logic runs on its rising edge.
REQ-005 SHALL have port i_vl_tx_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_valid, input, 1, RS-encoded byte valid; there is no backpressure.
REQ-007 SHALL have port i_sof, input, 1, first byte of frame, qualified by i_valid.
REQ-008 SHALL have port i_eof, input, 1, last byte of frame, qualified by i_valid.
REQ-009 SHALL have port i_data, input, 8, RS-encoded byte.
REQ-010 SHALL have port o_data, output, 16, framed word toward the header/p2s stage.
REQ-011 SHALL have port o_valid, output, 1, o_data valid.
REQ-012 SHALL have port i_ready, input, 1, downstream accepts the word.
REQ-013 SHALL have port o_sof, output, 1, first preamble word of frame.
REQ-014 SHALL have port o_eof, output, 1, last payload word of frame.
REQ-015 SHALL have port o_ovf, output, 1, sticky overflow/drop flag.
REQ-016 SHALL have port i_ovf_clr, input, 1, clears o_ovf.

Function
REQ-017 Write side: a byte is written when i_valid=1 and the frame is not in drop mode; i_sof resets the byte counter to 1.
REQ-018 On i_valid&i_eof, the frame length (1..1024, 11 bits) SHALL be pushed to an 8-entry length FIFO, committing the frame.
REQ-019 Byte FIFO full, length FIFO full, or length >1024 SHALL enter drop mode: write pointer rewinds to the frame start, o_ovf=1, and input is ignored until the next i_sof.
REQ-020 i_sof with a frame still open (no eof yet) SHALL discard the open frame (rewind), set o_ovf, and start the new frame.
REQ-021 Read FSM states: IDLE, PRE, SFD, LEN_H, LEN_L, PAY, GAP.
REQ-022 IDLE->PRE when the length FIFO is non-empty; the FSM pops the length.
REQ-023 PRE emits PRE_WORDS words of 16'hAAAA (o_sof on the first); SFD emits 16'hF0F0.
REQ-024 LEN_H/LEN_L emit Manchester({5'b0,len[10:8]}) and Manchester(len[7:0]).
REQ-025 PAY emits one Manchester word per FIFO byte, len words total; o_eof marks the last word; the FSM then enters GAP.
REQ-026 GAP holds o_valid=0 for GAP_CYC cycles, then returns to IDLE; back-to-back frames are therefore separated by exactly GAP_CYC idle cycles.
REQ-027 Manchester encoding: MSB first; bit 1 -> 2'b10, bit 0 -> 2'b01 (byte 8'hA5 -> 16'h9966).
REQ-028 Handshake: a word transfers on o_valid&i_ready; o_data/o_sof/o_eof SHALL hold stable while o_valid&~i_ready.
REQ-029 Latency: with i_ready=1, the first preamble word SHALL appear 2 cycles after the eof byte is written; output is one word per cycle with no bubbles within a frame.
REQ-030 Simultaneous write and read of the same FIFO SHALL be legal; pointers wrap modulo 2^FIFO_AW; full/empty SHALL be detected with an extra pointer bit.
REQ-031 i_ovf_clr with a simultaneous new overflow event SHALL leave o_ovf=1.

Reset
REQ-032 Asynchronous reset SHALL clear all pointers and counters, and set FSM=IDLE, o_valid=0, o_sof=0, o_eof=0, o_data=16'h0000, o_ovf=0.
REQ-033 Reset mid-frame SHALL discard all buffered and in-flight frames; no partial frame may be emitted after release.

Structure
REQ-034 The shared package tx_pkg SHALL hold PREAMBLE_WORD=16'hAAAA, SFD_WORD=16'hF0F0, MAX_LEN=1024, the FSM state enum, and a Manchester-encode function.
REQ-035 A single sub-module tx_sync_fifo (parameterised width/depth, registered read) SHALL be instantiated twice: the byte FIFO (8 bit x 1024) and the length FIFO (11 bit x 8).

Verification
REQ-036 Single 3-byte frame 8'hA5,8'h00,8'hFF, i_ready=1 -> 4x16'hAAAA, 16'hF0F0, 16'h5555, 16'h555A, 16'h9966, 16'h5555, 16'hAAAA, then 8 idle cycles.
REQ-037 Same frame with i_ready toggling 1/0 each cycle -> identical word sequence, and o_data stable while stalled.
REQ-038 Frame of 1025 bytes -> frame dropped, o_ovf=1, next 10-byte frame emitted correctly with len word 16'h5555/16'h5599.
REQ-039 i_sof mid-frame after 5 bytes, then 4-byte frame -> only the 4-byte frame is emitted, o_ovf=1.
REQ-040 9 committed 1-byte frames with i_ready=0 -> frames 1-8 buffered, frame 9 dropped, o_ovf=1; releasing i_ready emits 8 frames.
REQ-041 Reset asserted during PAY of a 100-byte frame -> outputs at reset values immediately; after release, o_valid stays 0 until a new frame arrives.
